// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with a 1-entry skid buffer, flush/stall handling,
// a saturating consecutive-stall counter and a sticky fetch-protocol error flag.
module if_id_pipe #(
   parameter int                DATA_W    = 16,
   parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(16'h0800),
   parameter int                CNT_W     = 4,
   parameter int                MAX_STALL = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] instr_in,
   input  logic [DATA_W-1:0] pc_plus2_in,
   input  logic              fetch_valid,
   input  logic              stall_decode,
   input  logic              flush_fetch,
   output logic [DATA_W-1:0] instr_out,
   output logic [DATA_W-1:0] pc_plus2_out,
   output logic              valid_out,
   output logic              fetch_stall,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic              stall_timeout,
   output logic              protocol_err
);

   logic [DATA_W-1:0] r_instr;
   logic [DATA_W-1:0] r_pc;
   logic              r_valid;
   logic [DATA_W-1:0] r_skid_instr;
   logic [DATA_W-1:0] r_skid_pc;
   logic              r_skid_valid;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              r_err;

   logic              w_capture;
   logic              w_violation;
   logic [CNT_W-1:0]  w_cnt_sat;

   if (MAX_STALL > (2**CNT_W) - 1) begin : g_bad_max_stall
      $error("if_id_pipe: MAX_STALL exceeds the range of the stall counter");
   end

   // A fetch arriving while the skid is occupied is dropped; a flush excuses it.
   assign w_violation = fetch_valid & r_skid_valid & ~flush_fetch;
   assign w_capture   = fetch_valid & ~r_skid_valid;
   assign w_cnt_sat   = (r_stall_cnt == {CNT_W{1'b1}}) ? r_stall_cnt : r_stall_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr      <= NOP_INSTR;
         r_pc         <= '0;
         r_valid      <= 1'b0;
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
         r_skid_valid <= 1'b0;
         r_stall_cnt  <= '0;
         r_err        <= 1'b0;
      end else begin
         if (w_violation) begin
            r_err <= 1'b1;
         end

         if (flush_fetch) begin
            r_instr      <= NOP_INSTR;
            r_pc         <= '0;
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_stall_cnt  <= '0;
         end else if (stall_decode) begin
            if (w_capture) begin
               r_skid_instr <= instr_in;
               r_skid_pc    <= pc_plus2_in;
               r_skid_valid <= 1'b1;
            end
            r_stall_cnt <= w_cnt_sat;
         end else begin
            // Skid drains before any newer fetch to preserve program order.
            if (r_skid_valid) begin
               r_instr      <= r_skid_instr;
               r_pc         <= r_skid_pc;
               r_valid      <= 1'b1;
               r_skid_valid <= 1'b0;
            end else if (fetch_valid) begin
               r_instr <= instr_in;
               r_pc    <= pc_plus2_in;
               r_valid <= 1'b1;
            end else begin
               r_instr <= NOP_INSTR;
               r_valid <= 1'b0;
            end
            r_stall_cnt <= '0;
         end
      end
   end

   assign instr_out     = r_instr;
   assign pc_plus2_out  = r_pc;
   assign valid_out     = r_valid;
   assign fetch_stall   = r_skid_valid;
   assign stall_cnt     = r_stall_cnt;
   assign stall_timeout = (r_stall_cnt >= CNT_W'(MAX_STALL));
   assign protocol_err  = r_err;

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed self-checking bench for if_id_pipe.
module tb_if_id_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr_in;
   logic [15:0] pc_plus2_in;
   logic        fetch_valid;
   logic        stall_decode;
   logic        flush_fetch;
   logic [15:0] instr_out;
   logic [15:0] pc_plus2_out;
   logic        valid_out;
   logic        fetch_stall;
   logic [3:0]  stall_cnt;
   logic        stall_timeout;
   logic        protocol_err;

   int checks = 0;
   int errors = 0;

   if_id_pipe dut (
      .clk          (clk),
      .rst          (rst),
      .instr_in     (instr_in),
      .pc_plus2_in  (pc_plus2_in),
      .fetch_valid  (fetch_valid),
      .stall_decode (stall_decode),
      .flush_fetch  (flush_fetch),
      .instr_out    (instr_out),
      .pc_plus2_out (pc_plus2_out),
      .valid_out    (valid_out),
      .fetch_stall  (fetch_stall),
      .stall_cnt    (stall_cnt),
      .stall_timeout(stall_timeout),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fv, input logic [15:0] ins, input logic [15:0] pc,
                        input logic st, input logic fl);
      fetch_valid  = fv;
      instr_in     = ins;
      pc_plus2_in  = pc;
      stall_decode = st;
      flush_fetch  = fl;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #3;
      check("rst_instr", instr_out, 16'h0800);
      check("rst_pc", pc_plus2_out, 16'h0000);
      check("rst_valid", 16'(valid_out), 16'd0);
      check("rst_fstall", 16'(fetch_stall), 16'd0);
      check("rst_cnt", 16'(stall_cnt), 16'd0);
      check("rst_tmo", 16'(stall_timeout), 16'd0);
      check("rst_err", 16'(protocol_err), 16'd0);
      tick();
      rst = 1'b0;

      // Streaming
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 16'hC000 + 16'(i), 16'(2 * i), 1'b0, 1'b0);
         tick();
         check("stream_instr", instr_out, 16'hC000 + 16'(i));
         check("stream_pc", pc_plus2_out, 16'(2 * i));
         check("stream_valid", 16'(valid_out), 16'd1);
         check("stream_fstall", 16'(fetch_stall), 16'd0);
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check("bubble_instr", instr_out, 16'h0800);
      check("bubble_valid", 16'(valid_out), 16'd0);
      check("bubble_pc_hold", pc_plus2_out, 16'h0008);

      // Stall with skid
      drive(1'b1, 16'hC001, 16'h0002, 1'b0, 1'b0);
      tick();
      check("sk_pre_instr", instr_out, 16'hC001);
      drive(1'b1, 16'hC002, 16'h0004, 1'b1, 1'b0);
      tick();
      check("sk1_instr", instr_out, 16'hC001);
      check("sk1_fstall", 16'(fetch_stall), 16'd1);
      check("sk1_cnt", 16'(stall_cnt), 16'd1);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      tick();
      check("sk2_instr", instr_out, 16'hC001);
      check("sk2_cnt", 16'(stall_cnt), 16'd2);
      tick();
      check("sk3_cnt", 16'(stall_cnt), 16'd3);
      check("sk3_fstall", 16'(fetch_stall), 16'd1);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check("skrel_instr", instr_out, 16'hC002);
      check("skrel_pc", pc_plus2_out, 16'h0004);
      check("skrel_valid", 16'(valid_out), 16'd1);
      check("skrel_cnt", 16'(stall_cnt), 16'd0);
      check("skrel_fstall", 16'(fetch_stall), 16'd0);

      // Flush priority over stall with a full skid
      drive(1'b1, 16'hC010, 16'h0010, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'hC011, 16'h0012, 1'b1, 1'b0);
      tick();
      check("fl_pre_fstall", 16'(fetch_stall), 16'd1);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
      tick();
      check("fl_instr", instr_out, 16'h0800);
      check("fl_valid", 16'(valid_out), 16'd0);
      check("fl_pc", pc_plus2_out, 16'h0000);
      check("fl_fstall", 16'(fetch_stall), 16'd0);
      check("fl_cnt", 16'(stall_cnt), 16'd0);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check("fl_skid_gone", instr_out, 16'h0800);
      // Fetch during flush with skid full is not an error
      drive(1'b1, 16'hC012, 16'h0014, 1'b1, 1'b0);
      tick();
      drive(1'b1, 16'hC013, 16'h0016, 1'b1, 1'b1);
      tick();
      check("fl_noerr", 16'(protocol_err), 16'd0);
      check("fl2_cnt", 16'(stall_cnt), 16'd0);

      // Timeout and saturation
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         tick();
         check("tmo_cnt", 16'(stall_cnt), (i > 15) ? 16'd15 : 16'(i));
         check("tmo_flag", 16'(stall_timeout), (i >= 12) ? 16'd1 : 16'd0);
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check("tmo_rel_cnt", 16'(stall_cnt), 16'd0);
      check("tmo_rel_flag", 16'(stall_timeout), 16'd0);

      // Protocol error during stall
      drive(1'b1, 16'hC020, 16'h0020, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'hC021, 16'h0022, 1'b1, 1'b0);
      tick();
      check("pe_pre_err", 16'(protocol_err), 16'd0);
      drive(1'b1, 16'hBEEF, 16'h00EE, 1'b1, 1'b0);
      tick();
      check("pe_err", 16'(protocol_err), 16'd1);
      check("pe_hold", instr_out, 16'hC020);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check("pe_drain", instr_out, 16'hC021);
      check("pe_drain_pc", pc_plus2_out, 16'h0022);
      tick();
      check("pe_bubble", instr_out, 16'h0800);
      check("pe_sticky", 16'(protocol_err), 16'd1);

      // Skid wins over a fetch on an advance cycle
      drive(1'b1, 16'hC030, 16'h0030, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'hC031, 16'h0032, 1'b1, 1'b0);
      tick();
      drive(1'b1, 16'hBEEF, 16'h00EE, 1'b0, 1'b0);
      tick();
      check("adv_skid_wins", instr_out, 16'hC031);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check("adv_drop", instr_out, 16'h0800);
      check("adv_sticky", 16'(protocol_err), 16'd1);

      // Asynchronous reset mid-operation
      drive(1'b1, 16'hC040, 16'h0040, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'hC041, 16'h0042, 1'b1, 1'b0);
      tick();
      check("ar_pre_valid", 16'(valid_out), 16'd1);
      check("ar_pre_fstall", 16'(fetch_stall), 16'd1);
      #2;
      rst = 1'b1;
      #1;
      check("ar_instr", instr_out, 16'h0800);
      check("ar_valid", 16'(valid_out), 16'd0);
      check("ar_fstall", 16'(fetch_stall), 16'd0);
      check("ar_cnt", 16'(stall_cnt), 16'd0);
      check("ar_err", 16'(protocol_err), 16'd0);
      #1;
      rst = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check("ar_after_instr", instr_out, 16'h0800);
      check("ar_after_err", 16'(protocol_err), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
- IF/ID pipeline register for the 5-stage WISC-SP20 core. Consumes the stall_decode and flush_fetch controls produced by hazard detection.
- Holds the decode-stage instruction on a stall and squashes it to a NOP on a flush.
- Absorbs one in-flight fetch during a stall in a 1-entry skid buffer, and back-pressures fetch when that buffer is occupied.
- Tracks consecutive stall cycles and raises a timeout flag for debug and verification.

Parameters:
- DATA_W, 16, instruction and PC width.
- NOP_INSTR, 16'h0800, encoding injected on bubble or flush (opcode 00001).
- CNT_W, 4, stall counter width.
- MAX_STALL, 12, consecutive-stall threshold for stall_timeout; must be ≤ 2^CNT_W-1.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_in  in  DATA_W  instruction from instruction memory.
- pc_plus2_in  in  DATA_W  PC+2 of instr_in.
- fetch_valid  in  1  instr_in/pc_plus2_in valid this cycle.
- stall_decode  in  1  hold the decode stage.
- flush_fetch  in  1  squash the decode stage (taken branch/jump).
- instr_out  out  DATA_W  instruction presented to decode.
- pc_plus2_out  out  DATA_W  PC+2 presented to decode.
- valid_out  out  1  instr_out is a real instruction (0 = bubble).
- fetch_stall  out  1  fetch must hold its PC and not present fetch_valid.
- stall_cnt  out  CNT_W  consecutive stall cycles, saturating.
- stall_timeout  out  1  stall_cnt ≥ MAX_STALL.
- protocol_err  out  1  sticky: fetch_valid seen while fetch_stall=1.

Behaviour:
- State:
  - main register {instr_q, pc_q, valid_q}
  - skid register {skid_instr, skid_pc, skid_valid}
  - stall_cnt_q
  - err_q
- Output mapping:
  - instr_out=instr_q, pc_plus2_out=pc_q, valid_out=valid_q.
  - fetch_stall=skid_valid, taken directly from the register with no combinational path from inputs.
  - stall_timeout=(stall_cnt_q≥MAX_STALL).
- Reset (async, immediate): instr_q=NOP_INSTR, pc_q=0, valid_q=0, skid_valid=0, skid data=0, stall_cnt_q=0, err_q=0. All outputs are therefore NOP_INSTR/0.
- Per-cycle priority is flush > stall > advance:
  - Flush (flush_fetch=1, stall_decode ignored): instr_q←NOP_INSTR, pc_q←0, valid_q←0, skid_valid←0. Any fetch_valid data this cycle is discarded. stall_cnt_q←0.
  - Stall (stall_decode=1, flush_fetch=0):
    - Main register holds.
    - If fetch_valid & ~skid_valid: skid←{instr_in, pc_plus2_in}, skid_valid←1.
    - stall_cnt_q←min(stall_cnt_q+1, 2^CNT_W-1).
  - Advance (both 0):
    - If skid_valid: main←skid, valid_q←1, skid_valid←0.
    - Else if fetch_valid: main←{instr_in, pc_plus2_in}, valid_q←1.
    - Else: bubble (instr_q←NOP_INSTR, valid_q←0, pc_q holds).
    - stall_cnt_q←0.
- Protocol check: fetch_valid=1 while skid_valid=1 is a fetch violation.
  - err_q←1, sticky until rst.
  - Offending data is dropped and never overwrites the skid.
  - Exception: a flush in the same cycle is not an error.
- Latency:
  - Input to instr_out is 1 cycle when not stalled.
  - Skid content drains on the first non-stall, non-flush cycle.
  - Order is preserved: skid content before any newer fetch.
- Ordering corner: skid_valid=1 and fetch_valid=1 on an advance cycle is a protocol error. The skid wins and the input is dropped.
- Sim-only assertion: MAX_STALL ≤ 2^CNT_W-1.

Test Plan:
- Reset mid-operation: with valid_q=1 and skid_valid=1, pulse rst asynchronously (not on a clock edge) → outputs go to instr_out=16'h0800, valid_out=0, fetch_stall=0, stall_cnt=0 immediately, before the next edge.
- Streaming: fetch_valid=1 for 4 cycles with instr 16'hC001..16'hC004 and no stall → instr_out shows each word one cycle later with valid_out=1; fetch_stall stays 0.
- Stall with skid:
  - Stimulus: instr_out=16'hC001, then assert stall_decode for 3 cycles while 16'hC002 is fetched in cycle 1.
  - Response: instr_out holds 16'hC001; skid captures 16'hC002; fetch_stall=1 from the next cycle; stall_cnt=1,2,3.
  - On release, instr_out=16'hC002 and stall_cnt=0.
- Flush priority: stall_decode=1, flush_fetch=1, skid full → next cycle instr_out=16'h0800, valid_out=0, fetch_stall=0, stall_cnt=0.
- Timeout and saturation: hold stall_decode for 20 cycles → stall_timeout rises when stall_cnt reaches 12; stall_cnt saturates at 15; both clear one cycle after release.
- Protocol error: drive fetch_valid=1 (instr 16'hBEEF) while fetch_stall=1 → protocol_err=1 and stays 1; 16'hBEEF never appears on instr_out; err clears only on rst.
